// File: rtl/divider_4bit_if.sv
// divider_4bit_if: request and result bundle for the 4-bit restoring divider
interface divider_4bit_if;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_4bit.sv
// divider_4bit: 4-bit unsigned restoring divider, one quotient bit per clock
module divider_4bit (
    input  logic           clk,
    input  logic           rst,
    divider_4bit_if.slave  io
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state_q, state_d;
    logic [4:0] p_q, p_d;
    logic [3:0] q_q, q_d;
    logic [3:0] dvs_q, dvs_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] quo_q, quo_d;
    logic [3:0] rem_q, rem_d;
    logic       dbz_q, dbz_d;
    logic       busy_q, done_q;
    logic [4:0] p_sh, dv5, t;
    logic       br;
    assign dv5 = {1'b0, dvs_q};
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        p_sh    = {p_q[3:0], q_q[3]};
        t       = '0;
        br      = 1'b0;
        // borrow-ripple subtract of the zero-extended divisor
        for (int i = 0; i < 5; i++) begin
            t[i] = p_sh[i] ^ dv5[i] ^ br;
            br   = (~p_sh[i] & dv5[i]) | (~(p_sh[i] ^ dv5[i]) & br);
        end
        if (state_q == RUN) begin
            p_d   = br ? p_sh : t;
            q_d   = {q_q[2:0], ~br};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                state_d = DONE;
                quo_d   = q_d;
                rem_d   = p_d[3:0];
            end
        end else if (io.start) begin
            dvs_d   = io.divisor;
            q_d     = io.dividend;
            p_d     = '0;
            cnt_d   = '0;
            dbz_d   = io.divisor == 4'd0;
            state_d = dbz_d ? DONE : RUN;
            quo_d   = dbz_d ? 4'hF : quo_q;
            rem_d   = dbz_d ? io.dividend : rem_q;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= state_d == RUN;
            done_q  <= state_d == DONE;
        end
    end
    assign io.busy        = busy_q;
    assign io.done        = done_q;
    assign io.quotient    = quo_q;
    assign io.remainder   = rem_q;
    assign io.div_by_zero = dbz_q;
endmodule
